// File: rtl/gsm_seq_pkg.sv
// Shared types and default sizing for the GSM FIR MAC phase sequencer.
package gsm_seq_pkg;

  localparam int unsigned NPHASE_DFLT   = 4;
  localparam int unsigned PHASE_W_DFLT  = 2;
  localparam int unsigned PIPE_LAT_DFLT = 3;
  localparam int unsigned CNT_W_DFLT    = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } seq_state_e;

  // Per-MAC-cycle tags carried alongside the product through the summing tree
  typedef struct packed {
    logic first;
    logic valid;
    logic last;
  } seq_tag_t;

endpackage

// File: rtl/gsm_mac_sequencer_if.sv
// Strobe-in / MAC-control-out bundle of the sequencer.
// Optional bank_req/bank_sel exist only with GSM_SEQ_BANK_SWITCH_EN defined.
interface gsm_mac_sequencer_if #(
  parameter int unsigned PHASE_W = gsm_seq_pkg::PHASE_W_DFLT,
  parameter int unsigned CNT_W   = gsm_seq_pkg::CNT_W_DFLT
);
  logic               sam_clk_en;
  logic               enable;
  logic               err_clr;
  logic [PHASE_W-1:0] phase;
  logic               mac_valid;
  logic               acc_clr;
  logic               acc_en;
  logic               out_load;
  logic               busy;
  logic               overrun;
  logic [CNT_W-1:0]   frame_cnt;
`ifdef GSM_SEQ_BANK_SWITCH_EN
  logic               bank_req;
  logic               bank_sel;

  modport master (output sam_clk_en, enable, err_clr, bank_req,
                  input  phase, mac_valid, acc_clr, acc_en, out_load, busy, overrun, frame_cnt,
                         bank_sel);
  modport slave  (input  sam_clk_en, enable, err_clr, bank_req,
                  output phase, mac_valid, acc_clr, acc_en, out_load, busy, overrun, frame_cnt,
                         bank_sel);
`else
  modport master (output sam_clk_en, enable, err_clr,
                  input  phase, mac_valid, acc_clr, acc_en, out_load, busy, overrun, frame_cnt);
  modport slave  (input  sam_clk_en, enable, err_clr,
                  output phase, mac_valid, acc_clr, acc_en, out_load, busy, overrun, frame_cnt);
`endif
endinterface

// File: rtl/gsm_seq_tag_delay.sv
// Tag shift register matching the mult-mux to accumulator pipeline depth.
module gsm_seq_tag_delay
  import gsm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_LAT_DFLT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  seq_tag_t tag_i,
  output seq_tag_t tag_o,
  output logic     any_valid_c
);

  seq_tag_t [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // first/last imply valid, so valid alone marks an occupied stage
  always_comb begin
    any_valid_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid_c = any_valid_c | pipe_q[i].valid;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/gsm_mac_sequencer.sv
// Phase scheduler for the time-shared GSM FIR MAC: phase select, aligned accumulator controls.
// Optional GSM_SEQ_BANK_SWITCH_EN latches bank_req into bank_sel on each accepted start.
module gsm_mac_sequencer
  import gsm_seq_pkg::*;
#(
  parameter int unsigned NPHASE   = NPHASE_DFLT,
  parameter int unsigned PHASE_W  = PHASE_W_DFLT,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DFLT,
  parameter int unsigned CNT_W    = CNT_W_DFLT
) (
  input logic                 sys_clk,
  input logic                 reset_n,
  gsm_mac_sequencer_if.slave  bus
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NPHASE - 1);

  seq_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               mac_valid_q, mac_valid_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               out_load_q;
  logic               busy_q;
  logic               start_c;
  logic               strobe_c;
  logic               last_phase_c;
  seq_tag_t           tag_c;
  seq_tag_t           tag_dly;
  logic               tag_any_c;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      mac_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      out_load_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      mac_valid_q <= mac_valid_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      out_load_q  <= tag_dly.last;
      busy_q      <= mac_valid_q | tag_any_c;
    end
  end

  // Next-state: accept starts in IDLE or on the final phase; mid-frame strobes only flag overrun
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    overrun_d    = overrun_q;
    frame_cnt_d  = frame_cnt_q;
    start_c      = 1'b0;
    strobe_c     = bus.sam_clk_en & bus.enable;
    last_phase_c = (phase_q == PHASE_LAST);

    if (bus.err_clr) overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (strobe_c) begin
          start_c = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        if (last_phase_c) begin
          phase_d = '0;
          if (strobe_c) start_c = 1'b1;
          else          state_d = IDLE;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
          if (strobe_c) overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    if (start_c) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    mac_valid_d = (state_d == MAC);

    tag_c.valid = mac_valid_q;
    tag_c.first = mac_valid_q & (phase_q == '0);
    tag_c.last  = mac_valid_q & last_phase_c;
  end

  gsm_seq_tag_delay #(
    .DEPTH (PIPE_LAT)
  ) u_tag_delay (
    .clk         (sys_clk),
    .rst_n       (reset_n),
    .tag_i       (tag_c),
    .tag_o       (tag_dly),
    .any_valid_c (tag_any_c)
  );

`ifdef GSM_SEQ_BANK_SWITCH_EN
  logic bank_sel_q;

  // Bank only moves on an accepted start so a frame never mixes coefficient sets
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)     bank_sel_q <= 1'b0;
    else if (start_c) bank_sel_q <= bus.bank_req;
  end

  assign bus.bank_sel = bank_sel_q;
`endif

  assign bus.phase     = phase_q;
  assign bus.mac_valid = mac_valid_q;
  assign bus.acc_clr   = tag_dly.first;
  assign bus.acc_en    = tag_dly.valid & ~tag_dly.first;
  assign bus.out_load  = out_load_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gsm_mac_sequencer.sv
// Directed bench for gsm_mac_sequencer; bank-switch steps run only with GSM_SEQ_BANK_SWITCH_EN.
module tb_gsm_mac_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   loads;
  int   last_load;
  int   cyc;
  int   acts;

  gsm_mac_sequencer_if bus ();

  gsm_mac_sequencer dut (
    .sys_clk (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected single-frame trace, index = cycles after the strobe cycle
  int e_ph   [1:9] = '{0, 1, 2, 3, 0, 0, 0, 0, 0};
  int e_mv   [1:9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
  int e_clr  [1:9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
  int e_en   [1:9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
  int e_ld   [1:9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  int e_busy [1:9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, 32'(bus.phase), 0);
    chk({tag, "_mac_valid"}, 32'(bus.mac_valid), 0);
    chk({tag, "_acc_clr"}, 32'(bus.acc_clr), 0);
    chk({tag, "_acc_en"}, 32'(bus.acc_en), 0);
    chk({tag, "_out_load"}, 32'(bus.out_load), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 0);
    chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.sam_clk_en = 1'b0;
    bus.enable     = 1'b0;
    bus.err_clr    = 1'b0;
`ifdef GSM_SEQ_BANK_SWITCH_EN
    bus.bank_req   = 1'b0;
`endif
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset_out_load", 32'(bus.out_load), 0);

    // 1: single frame latency trace
    bus.enable     = 1'b1;
    bus.sam_clk_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      bus.sam_clk_en = 1'b0;
      chk($sformatf("t1_phase_%0d", k), 32'(bus.phase), 32'(e_ph[k]));
      chk($sformatf("t1_mac_valid_%0d", k), 32'(bus.mac_valid), 32'(e_mv[k]));
      chk($sformatf("t1_acc_clr_%0d", k), 32'(bus.acc_clr), 32'(e_clr[k]));
      chk($sformatf("t1_acc_en_%0d", k), 32'(bus.acc_en), 32'(e_en[k]));
      chk($sformatf("t1_out_load_%0d", k), 32'(bus.out_load), 32'(e_ld[k]));
      chk($sformatf("t1_busy_%0d", k), 32'(bus.busy), 32'(e_busy[k]));
    end
    chk("t1_frame_cnt", 32'(bus.frame_cnt), 1);

    // 2: ten back-to-back frames
    do_reset();
    loads     = 0;
    last_load = 0;
    cyc       = 0;
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < 4; c++) begin
        bus.sam_clk_en = (c == 0);
        tick();
        cyc++;
        chk($sformatf("t2_phase_f%0d_c%0d", f, c), 32'(bus.phase), 32'(c));
        chk($sformatf("t2_mac_valid_f%0d_c%0d", f, c), 32'(bus.mac_valid), 1);
        if (bus.out_load) begin
          if (loads > 0) chk("t2_load_gap", 32'(cyc - last_load), 4);
          loads++;
          last_load = cyc;
        end
      end
    end
    bus.sam_clk_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cyc++;
      if (bus.out_load) begin
        if (loads > 0) chk("t2_load_gap", 32'(cyc - last_load), 4);
        loads++;
        last_load = cyc;
      end
    end
    chk("t2_load_count", 32'(loads), 10);
    chk("t2_overrun", 32'(bus.overrun), 0);
    chk("t2_frame_cnt", 32'(bus.frame_cnt), 10);

    // 3: overrun detection, clear, set-wins
    do_reset();
    bus.sam_clk_en = 1'b1;
    tick();
    bus.sam_clk_en = 1'b0;
    chk("t3_phase_1", 32'(bus.phase), 0);
    tick();
    bus.sam_clk_en = 1'b1;
    chk("t3_phase_2", 32'(bus.phase), 1);
    chk("t3_overrun_pre", 32'(bus.overrun), 0);
    tick();
    bus.sam_clk_en = 1'b0;
    chk("t3_overrun_set", 32'(bus.overrun), 1);
    chk("t3_phase_3", 32'(bus.phase), 2);
    tick();
    chk("t3_phase_4", 32'(bus.phase), 3);
    tick();
    chk("t3_mac_valid_end", 32'(bus.mac_valid), 0);
    chk("t3_frame_cnt", 32'(bus.frame_cnt), 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("t3_overrun_clr", 32'(bus.overrun), 0);
    bus.sam_clk_en = 1'b1;
    tick();
    bus.sam_clk_en = 1'b0;
    tick();
    bus.sam_clk_en = 1'b1;
    bus.err_clr    = 1'b1;
    tick();
    bus.sam_clk_en = 1'b0;
    bus.err_clr    = 1'b0;
    chk("t3_set_wins", 32'(bus.overrun), 1);
    for (int k = 0; k < 8; k++) tick();

    // 4: enable gating
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr    = 1'b0;
    bus.enable     = 1'b0;
    bus.sam_clk_en = 1'b1;
    tick();
    bus.sam_clk_en = 1'b0;
    chk("t4_dis_mac_valid", 32'(bus.mac_valid), 0);
    chk("t4_dis_overrun", 32'(bus.overrun), 0);
    tick();
    chk("t4_dis_phase", 32'(bus.phase), 0);
    chk("t4_dis_frame_cnt", 32'(bus.frame_cnt), 2);
    bus.enable     = 1'b1;
    bus.sam_clk_en = 1'b1;
    loads          = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      bus.sam_clk_en = 1'b0;
      bus.enable     = 1'b0;
      if (k == 4) chk("t4_drop_phase3", 32'(bus.phase), 3);
      if (k == 8) chk("t4_drop_out_load", 32'(bus.out_load), 1);
      if (bus.out_load) loads++;
    end
    chk("t4_drop_load_count", 32'(loads), 1);
    chk("t4_drop_frame_cnt", 32'(bus.frame_cnt), 3);

    // 5: async reset mid-frame
    bus.enable     = 1'b1;
    bus.sam_clk_en = 1'b1;
    tick();
    bus.sam_clk_en = 1'b0;
    tick();
    tick();
    chk("t5_phase_before", 32'(bus.phase), 2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    tick();
    rst_n = 1'b1;
    acts = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.acc_en || bus.out_load || bus.acc_clr || bus.mac_valid) acts++;
    end
    chk("t5_quiet_after_release", 32'(acts), 0);
    bus.sam_clk_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.sam_clk_en = 1'b0;
    end
    chk("t5_restart_acc_clr", 32'(bus.acc_clr), 1);
    for (int k = 0; k < 8; k++) tick();

`ifdef GSM_SEQ_BANK_SWITCH_EN
    // 6: bank select deferred to next accepted start
    do_reset();
    bus.bank_req   = 1'b0;
    bus.sam_clk_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.sam_clk_en = 1'b0;
      if (k == 2) bus.bank_req = 1'b1;
      chk($sformatf("t6_bank_hold_%0d", k), 32'(bus.bank_sel), 0);
    end
    bus.sam_clk_en = 1'b1;
    tick();
    bus.sam_clk_en = 1'b0;
    chk("t6_bank_switch", 32'(bus.bank_sel), 1);
    for (int k = 0; k < 8; k++) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
